// File: rtl/counter_updown_mod_pkg.sv
// Shared constants and parameter legality helper for the up/down modulus counter.
package counter_pkg;

  localparam bit COUNTER_WRAP     = 1'b0;
  localparam bit COUNTER_SATURATE = 1'b1;
  localparam bit COUNTER_UP       = 1'b0;
  localparam bit COUNTER_DOWN     = 1'b1;

  // Evaluated at elaboration; the top refuses to build when this returns 0.
  function automatic bit counter_params_ok(input int size,
                                           input longint unsigned modulus,
                                           input longint unsigned reset_value);
    return (size >= 1) && (size <= 32) && (modulus >= 2) &&
           (modulus <= (64'd1 << size)) && (reset_value < modulus);
  endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle of the up/down modulus counter.
interface counter_updown_mod_if #(parameter int Size = 8);

  logic            count;
  logic            down;
  logic            load;
  logic [Size-1:0] data_i;
  logic            clear_ovf;
  logic [Size-1:0] data_o;
  logic            tc;
  logic            ovf;
  logic            is_zero;
  logic            is_max;

  modport master (output count, down, load, data_i, clear_ovf,
                  input  data_o, tc, ovf, is_zero, is_max);
  modport slave  (input  count, down, load, data_i, clear_ovf,
                  output data_o, tc, ovf, is_zero, is_max);

endinterface

// File: rtl/counter_updown_mod_next.sv
// Combinational next-value and boundary calculator for the modulus counter.
module counter_next
  import counter_pkg::*;
#(
  parameter int              Size     = 8,
  parameter logic [Size-1:0] Max      = '1,
  parameter bit              Saturate = COUNTER_WRAP
) (
  input  logic [Size-1:0] q,
  input  logic            count,
  input  logic            down,
  input  logic            load,
  input  logic [Size-1:0] data_i,
  output logic [Size-1:0] nxt,
  output logic            boundary
);

  logic at_max, at_zero;

  assign at_max  = (q == Max);
  assign at_zero = (q == '0);

  // Only compares against Max and 0, so a non-power-of-two modulus never
  // relies on the natural 2**Size rollover.
  always_comb begin
    nxt      = q;
    boundary = 1'b0;
    if (load) begin
      nxt = (data_i > Max) ? Max : data_i;
    end else if (count) begin
      if (down == COUNTER_DOWN) begin
        if (at_zero) begin
          boundary = 1'b1;
          nxt      = (Saturate == COUNTER_SATURATE) ? '0 : Max;
        end else begin
          nxt = q - Size'(1);
        end
      end else begin
        if (at_max) begin
          boundary = 1'b1;
          nxt      = (Saturate == COUNTER_SATURATE) ? Max : '0;
        end else begin
          nxt = q + Size'(1);
        end
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulus counter with load, wrap/saturate, terminal-count strobe and sticky ovf.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int              Size       = 8,
  parameter longint unsigned Modulus    = 256,
  parameter bit              Saturate   = COUNTER_WRAP,
  parameter longint unsigned ResetValue = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  counter_updown_mod_if.slave         bus
);

  if (!counter_params_ok(Size, Modulus, ResetValue)) begin : g_bad_params
    $error("counter_updown_mod: illegal Size/Modulus/ResetValue combination");
  end

  localparam logic [Size-1:0] Max = Size'(Modulus - 64'd1);
  localparam logic [Size-1:0] Rst = Size'(ResetValue);

  logic [Size-1:0] q, nxt;
  logic            boundary, ovf_q;

  counter_next #(.Size(Size), .Max(Max), .Saturate(Saturate)) u_next (
    .q        (q),
    .count    (bus.count),
    .down     (bus.down),
    .load     (bus.load),
    .data_i   (bus.data_i),
    .nxt      (nxt),
    .boundary (boundary)
  );

  // Load suppresses boundary inside counter_next, so ovf only sees clear_ovf then.
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= Rst;
      ovf_q <= 1'b0;
    end else begin
      q <= nxt;
      if (boundary)           ovf_q <= 1'b1;
      else if (bus.clear_ovf) ovf_q <= 1'b0;
    end
  end

  assign bus.data_o  = q;
  assign bus.ovf     = ovf_q;
  assign bus.tc      = boundary & ~reset;
  assign bus.is_zero = (q == '0);
  assign bus.is_max  = (q == Max);

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the team's basic up-counter.
- Adds up/down counting, a synchronous parallel load, a programmable modulus, and a wrap or saturate mode.
- Adds a terminal-count strobe and a sticky overflow/underflow flag.
- Used as the general event/index counter in datapath and control blocks: timeouts, address generators, decade/BCD-style counting.

Parameters:
- Size, 8, width of data_i/data_o in bits; legal range 1..32.
- Modulus, 256, count range is 0..Modulus-1; Max = Modulus-1; requires 2 <= Modulus <= 2**Size.
- Saturate, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.
- ResetValue, 0, value loaded into data_o on reset; must be <= Max.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- count  input  1  advance the counter by one this cycle.
- down  input  1  direction: 0 = up, 1 = down; only meaningful when count=1.
- load  input  1  synchronous parallel load of data_i.
- data_i  input  Size  load value.
- clear_ovf  input  1  clears the sticky ovf flag.
- data_o  output  Size  current count (registered).
- tc  output  1  terminal-count strobe (combinational from registered state and inputs).
- ovf  output  1  sticky boundary-crossing flag (registered).
- is_zero  output  1  data_o == 0 (combinational from data_o).
- is_max  output  1  data_o == Max (combinational from data_o).

Behaviour:
- Interface: reset is synchronous, active-high; the clock is clock. All state updates occur on the rising edge of clock.
- Reset values: data_o = ResetValue, ovf = 0. After reset, is_zero and is_max follow data_o; tc = 0 unless inputs request a boundary count.
- Priority per edge: reset > load > count > hold.
- Load:
  - data_o <= data_i when data_i <= Max.
  - data_o <= Max otherwise (clamped).
  - count and down are ignored that cycle.
  - ovf is unaffected, except that clear_ovf still applies.
- Count up (count=1, down=0):
  - If data_o < Max: data_o <= data_o + 1.
  - If data_o == Max: data_o <= 0 when Saturate=0, or holds Max when Saturate=1.
- Count down (count=1, down=1):
  - If data_o > 0: data_o <= data_o - 1.
  - If data_o == 0: data_o <= Max when Saturate=0, or holds 0 when Saturate=1.
- Boundary event: boundary = count & ~load & ~reset & ((~down & is_max) | (down & is_zero)).
- tc:
  - tc = boundary, combinational.
  - Valid in the same cycle as the edge that wraps or saturates.
  - Zero-cycle latency; one cycle wide per event.
- ovf:
  - Set on the edge where boundary = 1.
  - Cleared on the edge where clear_ovf = 1 and boundary = 0.
  - If boundary and clear_ovf occur together, set wins (ovf = 1).
  - Reset clears ovf.
- Arithmetic:
  - Internal increment and decrement use Size-bit compares against Max and 0 only.
  - No reliance on natural 2**Size wrap, so non-power-of-two Modulus is exact.
- Latency: data_o changes one clock after count/load is sampled; no pipelining.
- Reset mid-operation: reset overrides a simultaneous load or count. data_o returns to ResetValue and ovf to 0 on that edge, and tc is 0.
- Direction change on consecutive cycles is legal; each cycle is evaluated independently.
- Saturate=1 at a boundary: data_o holds, tc pulses and ovf sets on every such count.

Decomposition:
- Package counter_pkg holds:
  - Mode constants COUNTER_WRAP = 0 and COUNTER_SATURATE = 1.
  - Direction constants COUNTER_UP = 0 and COUNTER_DOWN = 1.
  - Parameter legality checks (Modulus range, ResetValue <= Max) as elaboration-time assertions.
- One natural sub-module: counter_next, a purely combinational next-value/boundary calculator. It takes data_o, count, down and load/data_i, and outputs next value and boundary. The top level holds the registers, ovf and status decodes.

Test Plan:
1. Size=4, Modulus=10, Saturate=0; reset then count up for 12 cycles -> data_o 0..9,0,1,2. tc high only in the cycle data_o=9 with count=1. ovf=1 from the 10th edge onward.
2. Same configuration, down=1 from 0 -> data_o 9,8,...; tc in the cycle data_o=0. Pulse clear_ovf -> ovf=0 next edge. Clear and boundary in the same cycle -> ovf stays 1.
3. Saturate=1, Modulus=16; load 14, count up 4 cycles -> data_o 15,15,15,15. tc high in each of the last 3 cycles; is_max=1. Count down from 0 -> data_o holds 0, tc=1.
4. Modulus=10; load data_i=13 -> data_o=9 (clamped). Load and count together -> load wins, no tc.
5. ResetValue=5; count up to 7, then assert reset together with load=1, data_i=2 -> data_o=5 and ovf=0 next edge. Count continues from 5.
6. Alternate down=0/1 with count=1 at data_o=0 -> 1,0,1,0; tc only on down cycles at 0 (Saturate=0 wraps to 9 if issued).
